// File: rtl/exec_sequencer.sv
// Execute/commit sequencer: one decoded instruction in flight, branches and jumps resolved locally, ALU ops via enable/ready with timeout.
// Latency 2 cycles (branch/jump/illegal) or 3+wait cycles (ALU); issue_ready only in IDLE, so upstream stalls while an instruction is in flight.
module exec_sequencer #(
  parameter int XLEN        = 32,
  parameter int IBUS_W      = 37,
  parameter int ALU_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              issue_valid,
  output logic              issue_ready,
  input  logic [6:0]        opcode,
  input  logic [IBUS_W-1:0] instr_bus,
  input  logic [XLEN-1:0]   pc,
  input  logic [XLEN-1:0]   rs1_value,
  input  logic [XLEN-1:0]   rs2_value,
  input  logic [XLEN-1:0]   imm,
  input  logic              rd_valid,
  output logic              alu_enable,
  output logic [IBUS_W-1:0] alu_instr_bus,
  input  logic [XLEN-1:0]   alu_output,
  input  logic              alu_ready,
  output logic              rd_write,
  output logic [XLEN-1:0]   rd_data,
  output logic              redirect_valid,
  output logic [XLEN-1:0]   redirect_pc,
  output logic              done,
  output logic              trap_valid,
  output logic [1:0]        trap_cause
);

  typedef enum logic [1:0] {IDLE, EXEC, WAIT_ALU, COMMIT} state_t;

  typedef struct packed {
    logic [6:0]        opcode;
    logic [IBUS_W-1:0] ibus;
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   rs1;
    logic [XLEN-1:0]   rs2;
    logic [XLEN-1:0]   imm;
    logic              rd_valid;
  } issue_t;

  localparam logic [7:0] TO_LAST = 8'(ALU_TIMEOUT - 1);

  state_t            state, state_nxt;
  issue_t            cur;
  logic [7:0]        cnt, cnt_nxt;
  logic              alu_enable_nxt, rd_write_nxt, redirect_valid_nxt, done_nxt, trap_valid_nxt;
  logic [IBUS_W-1:0] alu_bus_nxt;
  logic [XLEN-1:0]   rd_data_nxt, redirect_pc_nxt;
  logic [1:0]        trap_cause_nxt;

  logic              is_alu, is_branch, is_jal, is_jalr, is_jump;
  logic              eq, lt, ltu, taken, redirect, misaligned;
  logic [XLEN-1:0]   jalr_sum, target, link;

  assign is_alu    = cur.opcode inside {7'b0110011, 7'b0010011, 7'b0000011,
                                        7'b0010111, 7'b0110111, 7'b0100011};
  assign is_branch = (cur.opcode == 7'b1100011);
  assign is_jal    = (cur.opcode == 7'b1101111);
  assign is_jalr   = (cur.opcode == 7'b1100111);
  assign is_jump   = is_jal | is_jalr;

  assign eq    = (cur.rs1 == cur.rs2);
  assign lt    = ($signed(cur.rs1) < $signed(cur.rs2));
  assign ltu   = (cur.rs1 < cur.rs2);
  assign taken = (cur.ibus[27] & eq) | (cur.ibus[28] & ~eq) |
                 (cur.ibus[29] & lt) | (cur.ibus[30] & ~lt) |
                 (cur.ibus[31] & ltu) | (cur.ibus[32] & ~ltu);

  assign jalr_sum   = cur.rs1 + cur.imm;
  assign target     = is_jalr ? {jalr_sum[XLEN-1:1], 1'b0} : (cur.pc + cur.imm);
  assign link       = cur.pc + XLEN'(4);
  assign redirect   = is_jump | (is_branch & taken);
  assign misaligned = (target[1:0] != 2'b00);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur <= '0;
    end else if (state == IDLE && issue_valid) begin
      cur <= '{opcode: opcode, ibus: instr_bus, pc: pc, rs1: rs1_value,
               rs2: rs2_value, imm: imm, rd_valid: rd_valid};
    end
  end

  always_comb begin
    state_nxt          = state;
    cnt_nxt            = cnt;
    alu_enable_nxt     = alu_enable;
    alu_bus_nxt        = alu_instr_bus;
    rd_data_nxt        = rd_data;
    redirect_pc_nxt    = redirect_pc;
    rd_write_nxt       = 1'b0;
    redirect_valid_nxt = 1'b0;
    done_nxt           = 1'b0;
    trap_valid_nxt     = 1'b0;
    trap_cause_nxt     = 2'd0;
    case (state)
      IDLE: if (issue_valid) state_nxt = EXEC;
      EXEC: begin
        if (is_alu) begin
          alu_enable_nxt = 1'b1;
          alu_bus_nxt    = cur.ibus;
          cnt_nxt        = '0;
          state_nxt      = WAIT_ALU;
        end else begin
          state_nxt = COMMIT;
          done_nxt  = 1'b1;
          if (!(is_branch || is_jump)) begin
            trap_valid_nxt = 1'b1;
            trap_cause_nxt = 2'd3;
          end else if (redirect && misaligned) begin
            // Target kept visible on redirect_pc for debug, but nothing is committed.
            redirect_pc_nxt = target;
            trap_valid_nxt  = 1'b1;
            trap_cause_nxt  = 2'd1;
          end else begin
            rd_write_nxt = cur.rd_valid;
            if (redirect) begin
              redirect_valid_nxt = 1'b1;
              redirect_pc_nxt    = target;
            end
            if (is_jump) rd_data_nxt = link;
          end
        end
      end
      WAIT_ALU: begin
        if (alu_ready) begin
          rd_data_nxt    = alu_output;
          rd_write_nxt   = cur.rd_valid;
          alu_enable_nxt = 1'b0;
          alu_bus_nxt    = '0;
          done_nxt       = 1'b1;
          state_nxt      = COMMIT;
        end else if (cnt == TO_LAST) begin
          alu_enable_nxt = 1'b0;
          alu_bus_nxt    = '0;
          done_nxt       = 1'b1;
          trap_valid_nxt = 1'b1;
          trap_cause_nxt = 2'd2;
          state_nxt      = COMMIT;
        end else begin
          cnt_nxt = cnt + 8'd1;
        end
      end
      COMMIT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      cnt            <= '0;
      issue_ready    <= 1'b1;
      alu_enable     <= 1'b0;
      alu_instr_bus  <= '0;
      rd_write       <= 1'b0;
      rd_data        <= '0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      done           <= 1'b0;
      trap_valid     <= 1'b0;
      trap_cause     <= 2'd0;
    end else begin
      state          <= state_nxt;
      cnt            <= cnt_nxt;
      issue_ready    <= (state_nxt == IDLE);
      alu_enable     <= alu_enable_nxt;
      alu_instr_bus  <= alu_bus_nxt;
      rd_write       <= rd_write_nxt;
      rd_data        <= rd_data_nxt;
      redirect_valid <= redirect_valid_nxt;
      redirect_pc    <= redirect_pc_nxt;
      done           <= done_nxt;
      trap_valid     <= trap_valid_nxt;
      trap_cause     <= trap_cause_nxt;
    end
  end

endmodule

// File: tb/tb_exec_sequencer.sv
// Directed bench for exec_sequencer: hand-computed expectations for branches, jumps, ALU handshake, timeout, illegal and reset.
module tb_exec_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        issue_valid;
  logic        issue_ready;
  logic [6:0]  opcode;
  logic [36:0] instr_bus;
  logic [31:0] pc, rs1_value, rs2_value, imm;
  logic        rd_valid;
  logic        alu_enable;
  logic [36:0] alu_instr_bus;
  logic [31:0] alu_output;
  logic        alu_ready;
  logic        rd_write;
  logic [31:0] rd_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        done;
  logic        trap_valid;
  logic [1:0]  trap_cause;

  int          checks = 0;
  int          passes = 0;
  int          fails  = 0;
  int          cyc, en_cnt, pulses;
  logic        ir_exec;
  logic [36:0] bus_seen;

  localparam logic [6:0] OP_ALU = 7'b0110011, OP_ALUI = 7'b0010011, OP_BR = 7'b1100011,
                         OP_JAL = 7'b1101111, OP_JALR = 7'b1100111;

  exec_sequencer dut (
    .clk(clk), .rst_n(rst_n), .issue_valid(issue_valid), .issue_ready(issue_ready),
    .opcode(opcode), .instr_bus(instr_bus), .pc(pc), .rs1_value(rs1_value),
    .rs2_value(rs2_value), .imm(imm), .rd_valid(rd_valid), .alu_enable(alu_enable),
    .alu_instr_bus(alu_instr_bus), .alu_output(alu_output), .alu_ready(alu_ready),
    .rd_write(rd_write), .rd_data(rd_data), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .done(done), .trap_valid(trap_valid), .trap_cause(trap_cause)
  );

  always #5 clk = ~clk;

  function automatic logic [36:0] bit_at(input int b);
    logic [36:0] one;
    one = 37'd1;
    return one << b;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [6:0] op, input logic [36:0] ib, input logic [31:0] p,
                       input logic [31:0] r1, input logic [31:0] r2, input logic [31:0] im,
                       input logic rdv);
    opcode = op; instr_bus = ib; pc = p; rs1_value = r1; rs2_value = r2; imm = im;
    rd_valid = rdv; issue_valid = 1'b1;
    tick();
    issue_valid = 1'b0;
  endtask

  // Runs from the cycle after accept (cycle 1) until done; alu_ready pulses in cycle ready_at.
  task automatic run(input int ready_at, input logic [31:0] aout);
    cyc = 1; en_cnt = 0; alu_output = aout;
    while (cyc < 100) begin
      alu_ready = (cyc == ready_at);
      if (cyc == 1) ir_exec = issue_ready;
      if (cyc == 2) bus_seen = alu_instr_bus;
      if (alu_enable) en_cnt++;
      if (done) break;
      tick();
      cyc++;
    end
    alu_ready = 1'b0;
    check("done_seen", done, 1);
  endtask

  initial begin
    rst_n = 1'b0; issue_valid = 1'b0; opcode = '0; instr_bus = '0; pc = '0;
    rs1_value = '0; rs2_value = '0; imm = '0; rd_valid = 1'b0; alu_output = '0; alu_ready = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    check("rst_issue_ready", issue_ready, 1);
    check("rst_alu_enable", alu_enable, 0);
    check("rst_done", done, 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_redirect_pc", redirect_pc, 0);
    check("rst_alu_bus", alu_instr_bus, 0);
    check("rst_trap_cause", trap_cause, 0);

    // beq taken
    issue(OP_BR, bit_at(27), 32'h100, 32'd5, 32'd5, 32'h20, 1'b0);
    run(0, 32'h0);
    check("beq_latency", cyc, 2);
    check("beq_ready_in_exec", ir_exec, 0);
    check("beq_redirect_valid", redirect_valid, 1);
    check("beq_redirect_pc", redirect_pc, 32'h120);
    check("beq_rd_write", rd_write, 0);
    check("beq_trap", trap_valid, 0);
    tick();
    check("beq_done_one_cycle", done, 0);
    check("beq_redirect_one_cycle", redirect_valid, 0);
    check("beq_ready_after", issue_ready, 1);

    // bltu unsigned: 0xFFFFFFFF < 1 is false
    issue(OP_BR, bit_at(31), 32'h200, 32'hFFFF_FFFF, 32'd1, 32'h40, 1'b0);
    run(0, 32'h0);
    check("bltu_latency", cyc, 2);
    check("bltu_not_taken", redirect_valid, 0);
    check("bltu_redirect_pc_held", redirect_pc, 32'h120);
    tick();

    // blt signed: -1 < 1 is true
    issue(OP_BR, bit_at(29), 32'h200, 32'hFFFF_FFFF, 32'd1, 32'h40, 1'b0);
    run(0, 32'h0);
    check("blt_taken", redirect_valid, 1);
    check("blt_redirect_pc", redirect_pc, 32'h240);
    tick();

    // bne with equal operands: not taken
    issue(OP_BR, bit_at(28), 32'h300, 32'd7, 32'd7, 32'h8, 1'b0);
    run(0, 32'h0);
    check("bne_not_taken", redirect_valid, 0);
    tick();

    // ADD with ready in the 4th wait cycle
    issue(OP_ALU, bit_at(0), 32'h400, 32'd1, 32'd2, 32'd0, 1'b1);
    run(5, 32'hDEAD_BEEF);
    check("add_latency", cyc, 6);
    check("add_enable_cycles", en_cnt, 4);
    check("add_alu_bus", bus_seen, bit_at(0));
    check("add_rd_write", rd_write, 1);
    check("add_rd_data", rd_data, 32'hDEAD_BEEF);
    check("add_alu_bus_cleared", alu_instr_bus, 0);
    check("add_no_redirect", redirect_valid, 0);
    tick();
    check("add_rd_write_one_cycle", rd_write, 0);

    // ALU immediate with ready in the first wait cycle
    issue(OP_ALUI, bit_at(1), 32'h404, 32'd1, 32'd0, 32'd3, 1'b1);
    run(2, 32'h0000_1234);
    check("addi_latency", cyc, 3);
    check("addi_enable_cycles", en_cnt, 1);
    check("addi_rd_data", rd_data, 32'h1234);
    tick();

    // JALR misaligned target 0x202
    issue(OP_JALR, bit_at(34), 32'h300, 32'h203, 32'd0, 32'd0, 1'b1);
    run(0, 32'h0);
    check("jalr_mis_latency", cyc, 2);
    check("jalr_mis_trap", trap_valid, 1);
    check("jalr_mis_cause", trap_cause, 1);
    check("jalr_mis_no_redirect", redirect_valid, 0);
    check("jalr_mis_no_write", rd_write, 0);
    tick();
    check("jalr_mis_trap_one_cycle", trap_valid, 0);

    // JALR aligned after bit-0 clear
    issue(OP_JALR, bit_at(34), 32'h300, 32'h201, 32'd0, 32'd0, 1'b1);
    run(0, 32'h0);
    check("jalr_redirect", redirect_valid, 1);
    check("jalr_redirect_pc", redirect_pc, 32'h200);
    check("jalr_rd_write", rd_write, 1);
    check("jalr_link", rd_data, 32'h304);
    check("jalr_no_trap", trap_valid, 0);
    tick();

    // JAL with wrapping target and link
    issue(OP_JAL, bit_at(33), 32'hFFFF_FFF0, 32'd0, 32'd0, 32'h20, 1'b1);
    run(0, 32'h0);
    check("jal_redirect_pc", redirect_pc, 32'h10);
    check("jal_link", rd_data, 32'hFFFF_FFF4);
    tick();

    // ALU timeout
    issue(OP_ALU, bit_at(2), 32'h500, 32'd0, 32'd0, 32'd0, 1'b1);
    run(0, 32'h0);
    check("to_latency", cyc, 17);
    check("to_enable_cycles", en_cnt, 15);
    check("to_trap", trap_valid, 1);
    check("to_cause", trap_cause, 2);
    check("to_no_write", rd_write, 0);
    check("to_enable_low", alu_enable, 0);
    tick();

    // illegal opcode
    issue(7'h7F, '0, 32'h600, 32'd0, 32'd0, 32'd0, 1'b1);
    run(0, 32'h0);
    check("ill_latency", cyc, 2);
    check("ill_cause", trap_cause, 3);
    check("ill_no_write", rd_write, 0);
    tick();

    // stray alu_ready in IDLE must not commit anything
    alu_ready = 1'b1;
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (done || rd_write) pulses++;
    end
    alu_ready = 1'b0;
    check("stray_ready_ignored", pulses, 0);

    // reset while in WAIT_ALU
    issue(OP_ALU, bit_at(3), 32'h700, 32'd0, 32'd0, 32'd0, 1'b1);
    tick();
    tick();
    check("midrst_enable_before", alu_enable, 1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_enable_async", alu_enable, 0);
    check("midrst_no_done", done, 0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    tick();
    check("midrst_ready_after", issue_ready, 1);
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      if (done || rd_write || trap_valid) pulses++;
      tick();
    end
    check("midrst_no_commit", pulses, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/exec_sequencer.md
# exec_sequencer

Parametrised execute/commit sequencer for the single-issue RISC-V core, sitting between decode/register-file read and the ALU/register-file write port. It accepts one decoded instruction per handshake and resolves branches and jumps with correct signed/unsigned comparison. It drives the ALU through an enable/ready handshake with timeout and produces single-cycle commit pulses: register write, PC redirect, done and trap. Compared with the fixed 4-phase predecessor, it is event-driven rather than free-running, width-parametrised, and it reports misaligned targets, ALU timeouts and illegal opcodes.

## Interface
- XLEN, 32, datapath width of PC, operands, immediate and results
- IBUS_W, 37, decoded one-hot instruction bus width (must be ≥ 35)
- ALU_TIMEOUT, 15, maximum WAIT_ALU cycles before trap (1..255)
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- issue_valid  in  1  decoded instruction and operands valid
- issue_ready  out  1  high only in IDLE; transfer on issue_valid & issue_ready
- opcode  in  7  instruction opcode
- instr_bus  in  IBUS_W  one-hot decode; bits 27..34 = beq, bne, blt, bge, bltu, bgeu, jal, jalr
- pc, rs1_value, rs2_value, imm  in  XLEN each  PC, operands, sign-extended immediate
- rd_valid  in  1  instruction writes rd
- alu_enable  out  1  ALU request, held until alu_ready sampled
- alu_instr_bus  out  IBUS_W  captured instr_bus while alu_enable, else 0
- alu_output  in  XLEN  ALU result
- alu_ready  in  1  ALU result valid
- rd_write  out  1  one-cycle register-file write strobe
- rd_data  out  XLEN  write data
- redirect_valid  out  1  one-cycle PC redirect strobe
- redirect_pc  out  XLEN  redirect target
- done  out  1  one-cycle completion pulse, every accepted instruction
- trap_valid  out  1  one-cycle trap pulse, coincident with done
- trap_cause  out  2  1 misaligned target, 2 ALU timeout, 3 illegal opcode; 0 otherwise

## Operation
- States: IDLE, EXEC, WAIT_ALU, COMMIT. All outputs registered.
- IDLE: issue_ready=1. On handshake, capture all inputs; go to EXEC.
- EXEC, by opcode class:
  - ALU class (0110011, 0010011, 0000011, 0010111, 0110111, 0100011): set alu_enable, alu_instr_bus; go to WAIT_ALU.
  - Branch (1100011): evaluate one-hot bit. beq/bne equality; blt/bge signed XLEN compare; bltu/bgeu unsigned full-XLEN compare. Taken: target = pc+imm. Go to COMMIT.
  - JAL (1101111): target = pc+imm, link = pc+4. JALR (1100111): target = (rs1_value+imm) with bit 0 cleared, link = pc+4. Link goes to rd_data without the ALU. Go to COMMIT.
  - Any other opcode: trap cause 3; go to COMMIT.
- Misalignment: a taken or jump target with bits[1:0] ≠ 0 gives trap cause 1, no redirect, no rd_write.
- WAIT_ALU: 8-bit counter from 0. On alu_ready: rd_data ← alu_output; drop alu_enable; clear alu_instr_bus; go to COMMIT. If the counter reaches ALU_TIMEOUT without ready: drop alu_enable, trap cause 2, go to COMMIT.
- COMMIT (exactly one cycle):
  - done=1.
  - rd_write=rd_valid & ~trap.
  - redirect_valid=taken/jump & ~trap.
  - trap_valid/trap_cause per above.
  - Then go to IDLE.
- Arithmetic is modulo 2^XLEN; pc+imm and pc+4 wrap silently.
- An alu_ready seen outside WAIT_ALU is ignored.

## Timing
- Reset values: state IDLE; issue_ready=1 after reset deassert. All other outputs 0, including rd_data, redirect_pc, alu_instr_bus and trap_cause.
- Reset mid-operation: the pending instruction is discarded with no commit pulses. alu_enable falls asynchronously.
- Branch/JAL/JALR/illegal: accept edge E0; COMMIT during cycle after E1. done is high 2 cycles after accept; throughput one instruction per 3 cycles.
- ALU op: alu_enable high from E1. If alu_ready is high in the first WAIT_ALU cycle, done is high 3 cycles after accept. Each wait cycle adds 1.
- Timeout: alu_enable is high for exactly ALU_TIMEOUT cycles, then COMMIT.
- issue_ready=0 in EXEC, WAIT_ALU and COMMIT; issue_valid is ignored there.
- rd_data and redirect_pc hold their value until the next commit that updates them.

## Test plan
- Reset then beq, rs1=rs2=5, pc=0x100, imm=0x20 -> done 2 cycles after accept, redirect_valid=1, redirect_pc=0x120, rd_write=0.
- bltu rs1=0xFFFFFFFF, rs2=1 -> not taken; blt with same operands -> taken.
- ADD with alu_ready delayed 4 cycles, rd_valid=1, alu_output=0xDEADBEEF -> alu_enable high 4 cycles, rd_write pulse with rd_data=0xDEADBEEF, done 6 cycles after accept.
- JALR rs1=0x203, imm=0 -> target 0x202, trap_valid=1 cause 1, no redirect, no rd_write; with rs1=0x201 -> redirect_pc=0x200, rd_data=pc+4.
- ALU op with alu_ready stuck 0 -> alu_enable high ALU_TIMEOUT cycles, trap cause 2, done=1, rd_write=0; opcode 0x7F -> trap cause 3.
- rst_n asserted while in WAIT_ALU -> alu_enable 0 immediately, no done pulse, issue_ready=1 on the first cycle after release.
